// File: rtl/and_gate_sweep_ctrl_pkg.sv
// Shared types and constants for the exhaustive 4-input AND gate sweep controller.
package and_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int          VEC_COUNT   = 16;
  localparam logic [3:0]  LAST_VEC    = 4'(VEC_COUNT - 1);
  localparam logic [15:0] AND4_GOLDEN = 16'h8000;

endpackage

// File: rtl/and_gate_sweep_ctrl_if.sv
// Bundle between the sweep controller (master) and the board/gate side (slave).
interface and_gate_sweep_ctrl_if;
  import and_sweep_pkg::*;

  // start is a request level sampled only while idle; busy acknowledges it from the
  // following cycle, and done pulses once when results are valid and held until the next start.
  logic        start;
  logic        gate_a;
  logic        gate_b;
  logic        gate_c;
  logic        gate_d;
  logic        gate_e;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] truth_table;
  logic        fail_valid;
  logic [3:0]  fail_index;
  state_t      dbg_state;

  modport master (
    input  start, gate_e,
    output gate_a, gate_b, gate_c, gate_d,
    output busy, done, pass, truth_table, fail_valid, fail_index, dbg_state
  );

  modport slave (
    output start, gate_e,
    input  gate_a, gate_b, gate_c, gate_d,
    input  busy, done, pass, truth_table, fail_valid, fail_index, dbg_state
  );

endinterface

// File: rtl/and_gate_sweep_ctrl_timer.sv
// Settle timer: 4-bit down-counter with load; expire is high once the count reaches zero.
module sweep_settle_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic       o_expire
);

  logic [3:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 4'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign o_expire = (r_count == 4'd0);

endmodule

// File: rtl/and_gate_sweep_ctrl.sv
// Drives all 16 vectors onto the gate under test, captures its output per vector and
// grades the resulting truth table against a golden pattern.
module and_gate_sweep_ctrl
  import and_sweep_pkg::*;
#(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] EXPECTED      = AND4_GOLDEN
) (
  input  logic                  clk,
  input  logic                  reset,
  and_gate_sweep_ctrl_if.master bus
);

  // Timer is loaded with SETTLE_CYCLES-1 so SETTLE lasts exactly SETTLE_CYCLES cycles.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_vec;
  logic [15:0] r_table;
  logic [15:0] w_table_next;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic        r_fail_valid;
  logic [3:0]  r_fail_index;
  logic        w_accept;
  logic        w_sample;
  logic        w_advance;
  logic        w_finish;
  logic        w_expire;
  logic        w_drive;
  logic        w_mismatch;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_sample  = 1'b0;
    w_advance = 1'b0;
    w_finish  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = SETTLE;
        end
      end
      SETTLE: begin
        if (w_expire) w_next = SAMPLE;
      end
      SAMPLE: begin
        w_sample = 1'b1;
        if (r_vec == LAST_VEC) begin
          w_finish = 1'b1;
          w_next   = DONE;
        end else begin
          w_advance = 1'b1;
          w_next    = SETTLE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  sweep_settle_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_accept | w_advance),
    .i_load_val (SETTLE_LOAD),
    .i_dec      (r_state == SETTLE),
    .o_expire   (w_expire)
  );

  // Table as it will look after this sample; pass is graded on it so it lands with done.
  always_comb begin
    w_table_next        = r_table;
    w_table_next[r_vec] = bus.gate_e;
  end

  assign w_mismatch = (bus.gate_e != EXPECTED[r_vec]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vec        <= 4'd0;
      r_table      <= 16'h0000;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail_valid <= 1'b0;
      r_fail_index <= 4'd0;
    end else begin
      r_done <= w_finish;
      if (w_accept) begin
        r_vec        <= 4'd0;
        r_table      <= 16'h0000;
        r_fail_valid <= 1'b0;
        r_fail_index <= 4'd0;
        r_pass       <= 1'b0;
        r_busy       <= 1'b1;
      end
      if (w_sample) begin
        r_table <= w_table_next;
        if (w_mismatch && !r_fail_valid) begin
          r_fail_valid <= 1'b1;
          r_fail_index <= r_vec;
        end
      end
      if (w_advance) r_vec <= r_vec + 4'd1;
      if (w_finish)  r_pass <= (w_table_next == EXPECTED);
      if (r_state == DONE) r_busy <= 1'b0;
    end
  end

  assign w_drive         = (r_state == SETTLE) || (r_state == SAMPLE);
  assign bus.gate_a      = w_drive & r_vec[3];
  assign bus.gate_b      = w_drive & r_vec[2];
  assign bus.gate_c      = w_drive & r_vec[1];
  assign bus.gate_d      = w_drive & r_vec[0];
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.pass        = r_pass;
  assign bus.truth_table = r_table;
  assign bus.fail_valid  = r_fail_valid;
  assign bus.fail_index  = r_fail_index;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_and_gate_sweep_ctrl.sv
// Bench for and_gate_sweep_ctrl: two instances (settle 2 and settle 1) against a
// cycle-index reference model, plus directed literal checks.
module tb_and_gate_sweep_ctrl;
  import and_sweep_pkg::*;

  localparam int          S0     = 2;
  localparam int          S1     = 1;
  localparam logic [15:0] EXP    = AND4_GOLDEN;
  localparam logic [15:0] F_AND  = 16'h8000;
  localparam logic [15:0] F_OR   = 16'hFFFE;
  localparam logic [15:0] F_ZERO = 16'h0000;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] fn    = F_AND;
  int          n_cmp = 0;
  int          n_bad = 0;

  and_gate_sweep_ctrl_if bus0 ();
  and_gate_sweep_ctrl_if bus1 ();

  assign bus0.start  = start;
  assign bus1.start  = start;
  assign bus0.gate_e = fn[{bus0.gate_a, bus0.gate_b, bus0.gate_c, bus0.gate_d}];
  assign bus1.gate_e = fn[{bus1.gate_a, bus1.gate_b, bus1.gate_c, bus1.gate_d}];

  and_gate_sweep_ctrl #(.SETTLE_CYCLES(S0), .EXPECTED(EXP)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  and_gate_sweep_ctrl #(.SETTLE_CYCLES(S1), .EXPECTED(EXP)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Per instance: whether a sweep is running, the cycle index inside it (0 = first cycle
  // after acceptance), the gate function it saw, and whether a finished result is held.
  bit        m_busy [2];
  int        m_c    [2];
  bit [15:0] m_f    [2];
  bit        m_have [2];

  logic [27:0] obs [2];
  assign obs[0] = {bus0.busy, bus0.done, bus0.pass, bus0.fail_valid, bus0.fail_index,
                   bus0.truth_table, bus0.gate_a, bus0.gate_b, bus0.gate_c, bus0.gate_d};
  assign obs[1] = {bus1.busy, bus1.done, bus1.pass, bus1.fail_valid, bus1.fail_index,
                   bus1.truth_table, bus1.gate_a, bus1.gate_b, bus1.gate_c, bus1.gate_d};

  function automatic int settle_of(input int d);
    return (d == 0) ? S0 : S1;
  endfunction

  function automatic logic [15:0] mask_n(input int n);
    if (n >= 16) return 16'hFFFF;
    return 16'((32'd1 << n) - 32'd1);
  endfunction

  function automatic logic [3:0] lowest(input logic [15:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 15; i >= 0; i--) if (v[i]) r = 4'(i);
    return r;
  endfunction

  function automatic void model_step(input int d, input bit r, input bit s);
    int len;
    len = 16 * (settle_of(d) + 1);
    if (r) begin
      m_busy[d] = 1'b0;
      m_have[d] = 1'b0;
      m_c[d]    = 0;
    end else if (!m_busy[d]) begin
      if (s) begin
        m_busy[d] = 1'b1;
        m_c[d]    = 0;
        m_f[d]    = fn;
        m_have[d] = 1'b0;
      end
    end else begin
      m_c[d] = m_c[d] + 1;
      if (m_c[d] == len + 1) begin
        m_busy[d] = 1'b0;
        m_have[d] = 1'b1;
      end
    end
  endfunction

  // Expected {busy,done,pass,fail_valid,fail_index,truth_table,gate vector}.
  function automatic logic [27:0] expect_of(input int d);
    int          s, len, n;
    logic [15:0] tt, mm;
    logic        dn, ps;
    logic [3:0]  g;
    s   = settle_of(d);
    len = 16 * (s + 1);
    dn  = 1'b0;
    ps  = 1'b0;
    g   = 4'd0;
    n   = 0;
    if (m_busy[d]) begin
      n = (m_c[d] < len) ? m_c[d] / (s + 1) : 16;
      if (m_c[d] < len) g = 4'(m_c[d] / (s + 1));
      dn = (m_c[d] == len);
      if (dn) ps = (m_f[d] == EXP);
    end else if (m_have[d]) begin
      n  = 16;
      ps = (m_f[d] == EXP);
    end
    tt = m_f[d] & mask_n(n);
    mm = (m_f[d] ^ EXP) & mask_n(n);
    return {m_busy[d], dn, ps, (mm != 16'h0), lowest(mm), tt, g};
  endfunction

  // ---------------- scoreboard: per-cycle compare ----------------
  always @(posedge clk) begin
    bit          r, s;
    logic [27:0] e;
    r = reset;
    s = start;
    for (int d = 0; d < 2; d++) model_step(d, r, s);
    #1;
    for (int d = 0; d < 2; d++) begin
      e = expect_of(d);
      n_cmp++;
      if (obs[d] !== e) begin
        n_bad++;
        $display("FAIL cycle_check dut%0d t=%0t got=%h want=%h (busy,done,pass,fv,fi,tt,gates)",
                 d, $time, obs[d], e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300; k++) begin
      if (!bus0.busy && !bus1.busy) break;
      @(negedge clk);
    end
    check("wait_idle", 32'({bus0.busy, bus1.busy}), 32'd0);
    @(negedge clk);
  endtask

  // Pulse start once; lat = cycles from acceptance edge (counted 1) to the done cycle.
  task automatic run_sweep(input logic [15:0] f, output int lat0, output int lat1);
    lat0 = -1;
    lat1 = -1;
    @(negedge clk);
    fn    = f;
    start = 1'b1;
    for (int cnt = 1; cnt <= 200 && lat0 < 0; cnt++) begin
      @(negedge clk);
      start = 1'b0;
      if (bus1.done && lat1 < 0) lat1 = cnt;
      if (bus0.done) lat0 = cnt;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int l0, l1, dones, lows, k;
    bit found;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs0", 32'(obs[0]), 32'd0);
    check("reset_outputs1", 32'(obs[1]), 32'd0);
    check("reset_state0", 32'(bus0.dbg_state), 32'(IDLE));
    check("reset_state1", 32'(bus1.dbg_state), 32'(IDLE));
    reset = 1'b0;
    @(negedge clk);

    // Correct AND4
    run_sweep(F_AND, l0, l1);
    check("and_latency_s2", 32'(l0), 32'd49);
    check("and_latency_s1", 32'(l1), 32'd33);
    check("and_table", 32'(bus0.truth_table), 32'h8000);
    check("and_pass", 32'(bus0.pass), 32'd1);
    check("and_fail_valid", 32'(bus0.fail_valid), 32'd0);
    check("and_table_s1", 32'(bus1.truth_table), 32'h8000);
    wait_idle();

    // Output stuck at 0
    run_sweep(F_ZERO, l0, l1);
    check("zero_table", 32'(bus0.truth_table), 32'h0000);
    check("zero_pass", 32'(bus0.pass), 32'd0);
    check("zero_fail_valid", 32'(bus0.fail_valid), 32'd1);
    check("zero_fail_index", 32'(bus0.fail_index), 32'd15);
    wait_idle();

    // OR4 substituted
    run_sweep(F_OR, l0, l1);
    check("or_table", 32'(bus0.truth_table), 32'hFFFE);
    check("or_pass", 32'(bus0.pass), 32'd0);
    check("or_fail_index", 32'(bus0.fail_index), 32'd1);
    check("or_fail_index_s1", 32'(bus1.fail_index), 32'd1);
    wait_idle();

    // start held high for 60 cycles
    fn    = F_AND;
    start = 1'b1;
    dones = 0;
    lows  = 0;
    for (int cnt = 1; cnt <= 60; cnt++) begin
      @(negedge clk);
      if (bus0.done) dones++;
      if (!bus0.busy) lows++;
      if (cnt == 51) check("held_restart_busy", 32'(bus0.busy), 32'd1);
    end
    start = 1'b0;
    check("held_done_count", 32'(dones), 32'd1);
    check("held_busy_low_count", 32'(lows), 32'd1);
    wait_idle();

    // Reset while vec = 7, with a partial table already captured
    @(negedge clk);
    fn    = F_OR;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int cnt = 0; cnt < 100 && !found; cnt++) begin
      if ({bus0.gate_a, bus0.gate_b, bus0.gate_c, bus0.gate_d} == 4'd7) found = 1'b1;
      else @(negedge clk);
    end
    check("reach_vec7", 32'(found), 32'd1);
    check("partial_table_vec7", 32'(bus0.truth_table), 32'h007E);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_busy", 32'(bus0.busy), 32'd0);
    check("midreset_table", 32'(bus0.truth_table), 32'd0);
    check("midreset_gates", 32'({bus0.gate_a, bus0.gate_b, bus0.gate_c, bus0.gate_d}), 32'd0);
    run_sweep(F_AND, l0, l1);
    check("post_reset_latency", 32'(l0), 32'd49);
    check("post_reset_table", 32'(bus0.truth_table), 32'h8000);
    check("post_reset_pass", 32'(bus0.pass), 32'd1);
    wait_idle();

    // Randomized: random gate functions, stray starts and occasional resets
    for (int it = 0; it < 30; it++) begin
      fn = ($urandom_range(0, 3) == 0) ? EXP : 16'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      start = 1'b1;
      k = $urandom_range(20, 80);
      for (int j = 0; j < k; j++) begin
        @(negedge clk);
        start = ($urandom_range(0, 9) == 0);
        reset = ($urandom_range(0, 99) == 0);
      end
      start = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      wait_idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/and_gate_sweep_ctrl.md
# and_gate_sweep_ctrl

Sequencing controller that exercises the lab's 4-input AND gate datapath exhaustively. On a start pulse it drives all 16 input vectors onto the gate in order. For each vector it waits a configurable settle time, then captures the gate output into a 16-bit truth table. At the end it compares the table against a golden pattern and reports pass/fail and the first mismatching index. It sits between the board-level start button/LED logic and the gate under test.

## Interface
Parameters:
- SETTLE_CYCLES, 2: cycles each vector is held before sampling; legal range 1..15.
- EXPECTED, 16'h8000: golden truth table; bit i is the expected output for vector i.

Ports:
- clk  in  1  single system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begins a sweep; sampled only in IDLE.
- gate_a, gate_b, gate_c, gate_d  out  1 each  gate inputs; gate_a = vec[3], gate_d = vec[0].
- gate_e  in  1  gate output, combinational from gate_a..gate_d.
- busy  out  1  high from the cycle after start is accepted until DONE is left.
- done  out  1  one-cycle pulse when the sweep completes.
- pass  out  1  truth_table == EXPECTED; updated with done, held until the next start.
- truth_table  out  16  captured outputs; bit i holds the result for vector i.
- fail_valid  out  1  at least one mismatch in the last sweep.
- fail_index  out  4  lowest mismatching vector index; 0 when fail_valid = 0.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: gate inputs = 0, busy = 0. On start = 1: vec <= 0, cnt <= 0, truth_table <= 0, fail_valid <= 0, fail_index <= 0, pass <= 0, busy <= 1, go to SETTLE.
- SETTLE: drive vec. Increment cnt. When cnt == SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE: drive vec. truth_table[vec] <= gate_e.
  - If gate_e != EXPECTED[vec] and fail_valid = 0: fail_valid <= 1, fail_index <= vec.
  - If vec == 15: go to DONE. Otherwise vec <= vec+1, cnt <= 0, go to SETTLE.
- DONE: done = 1 for exactly this cycle. Gate inputs return to 0. Go to IDLE, and busy drops on that transition.
- pass is computed as the complement of the final mismatch flag, i.e. it equals (truth_table == EXPECTED), and is registered on the SAMPLE→DONE edge.
- Boundary conditions:
  - start while busy, or in the DONE cycle: ignored. A held start retriggers only once the block is back in IDLE.
  - vec wraps nowhere; the sweep terminates at vec = 15.
  - reset and start in the same cycle: reset wins.
  - reset mid-sweep: on the next edge the block returns to IDLE, all outputs take their reset values, and the partial table is discarded.

## Timing
- Reset values: gate_a..d = 0, busy = 0, done = 0, pass = 0, truth_table = 16'h0000, fail_valid = 0, fail_index = 0. State is IDLE.
- Per-vector cost: SETTLE_CYCLES + 1 cycles.
- Latency: start accepted at edge N; done is high in the cycle following edge N + 16*(SETTLE_CYCLES+1). For SETTLE_CYCLES = 2 that is edge N+48.
- truth_table, pass, fail_valid and fail_index are valid when done is high and are stable until the next accepted start.
- Outputs are registered except gate_a..d, which decode directly from state and vec with no combinational path from gate_e.

## Structure
- Shared package and_sweep_pkg:
  - state enum {IDLE, SETTLE, SAMPLE, DONE};
  - VEC_COUNT = 16;
  - AND4_GOLDEN = 16'h8000.
- One natural sub-module, sweep_settle_timer: a 4-bit down-counter with load and an expire flag, instantiated once.
- The gate itself stays outside this block and is connected at the top level.

## Test plan
- Correct AND4 model, SETTLE_CYCLES = 2, start pulse → done at N+48; truth_table = 16'h8000, pass = 1, fail_valid = 0.
- gate_e stuck at 0 → truth_table = 16'h0000, pass = 0, fail_valid = 1, fail_index = 15.
- OR4 model substituted → truth_table = 16'hFFFE, pass = 0, fail_index = 1.
- start held high for 60 cycles → exactly one sweep runs during the first 49 cycles. A second sweep starts immediately after return to IDLE. busy never glitches low inside a sweep.
- reset asserted while vec = 7 → next edge: busy = 0, truth_table = 0, gate inputs = 0. A following start runs a full, correct sweep.
- SETTLE_CYCLES = 1 → done at N+32; gate input sequence 0..15, each held 2 cycles.
